pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Upstream fetch stage of the single-cycle processor. Owns the program counter and produces the word address that drives the instruction ROM's PC_In. Computes the next PC from sequential increment, taken branch or jump. Adds run/stall/halt control and a pending-redirect buffer so control-flow decisions made during a stall are not lost.

Parameters:
ADDR_W, 5, number of significant PC bits; matches 2^ADDR_W-word instruction ROM (32 words)
RESET_PC, 0, word address loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; IDLE->RUN when high
stall  input  1  hold PC this cycle
branch_taken  input  1  decoder/ALU: branch condition true for current instr
branch_offset  input  16  signed word offset (instr[15:0])
jump  input  1  current instr is J-type jump
jump_target  input  26  word target (instr[25:0])
halt  input  1  stop fetching permanently until reset
PC_Out  output  32  current PC word address to ROM PC_In; bits [31:ADDR_W] always 0
pc_plus1  output  32  PC_Out+1, masked to ADDR_W bits
fetch_valid  output  1  high when PC_Out is a live fetch (RUN, not stalled)
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 STALL, 11 HALT

Behaviour:
- Reset (rst_n=0, async): PC=RESET_PC, state=IDLE, fetch_valid=0, pending redirect cleared. Reset mid-operation discards everything, no partial update.
- All PC arithmetic modulo 2^ADDR_W; upper bits of PC_Out/pc_plus1 forced 0. PC=31 -> next 0 (wrap, no error).
- Branch target = PC+1+sext(branch_offset), truncated to ADDR_W. Jump target = jump_target[ADDR_W-1:0].
- Redirect priority: jump > branch_taken > sequential.
- IDLE: PC held, fetch_valid=0; en=1 -> RUN next edge (first fetch at RESET_PC).
- RUN: fetch_valid=1. Each edge: halt -> HALT (PC not updated); else stall -> STALL, PC held, any jump/branch this cycle stored in pending register (target + valid); else PC <= selected next PC. en=0 -> IDLE, PC held.
- STALL: fetch_valid=0, PC held. New jump/branch while stalled overwrite pending (jump still wins within a cycle). On stall=0: PC <= pending target if valid else PC+1... no: PC held, then in the release cycle apply pending if valid, else resume normal next-PC from current inputs; pending cleared; -> RUN. halt in STALL -> HALT, pending dropped.
- HALT: PC frozen, fetch_valid=0, all inputs ignored; exit only via reset.
- Simultaneous halt+stall+redirect: halt wins. en=0 with stall: stall state retained until release, then IDLE check.
- Latency: redirect asserted in cycle N visible on PC_Out after edge N (one cycle), or on the edge ending the stall if buffered.
- PC_Out is a register output; pc_plus1 combinational from PC.

Optional Feature:
FETCH_PERF_CNT_EN: defined -> adds outputs fetch_count[31:0] (increments each cycle fetch_valid=1) and redirect_count[15:0] (increments on each applied jump/branch redirect, including buffered ones), both reset to 0, saturating at all-ones. Undefined -> ports and counters absent; core behaviour identical.

Test Plan:
- Reset, en=1, no redirects 6 cycles -> PC_Out 0,1,2,3,4,5; fetch_valid=1 from first RUN cycle.
- At PC=10 branch_taken=1, offset=3 -> next PC_Out=14; offset=16'hFFFE at PC=5 -> 4.
- At PC=16 jump=1, jump_target=0x14 together with branch_taken=1 -> PC_Out=20 (jump priority).
- Run to PC=31, no redirect -> next PC_Out=0, PC_Out[31:5]=0.
- At PC=7 stall=1 with branch_taken offset=2, hold stall 3 cycles, release -> PC stays 7 while stalled, fetch_valid=0, then PC_Out=10.
- halt at PC=9 -> state=HALT, PC_Out=9 forever despite en/jump; pulse rst_n low asynchronously mid-cycle -> PC_Out=0, state=IDLE immediately.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage program counter with run/stall/halt control.
// Produces the word address for the instruction ROM. The next PC is chosen
// from sequential increment, taken branch or jump (jump > branch > sequential).
// A pending-redirect buffer holds a control-flow decision made while stalled.
// If the FETCH_PERF_CNT_EN macro is defined, the fetch and redirect
// performance counters are added as extra outputs.
module pc_fetch_unit #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        halt,
  output logic [31:0] PC_Out,
  output logic [31:0] pc_plus1,
  output logic        fetch_valid,
  output logic [1:0]  state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] redirect_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_STALL = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_fetch_valid;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_tgt;

  logic [31:0]       w_off_sext;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_jmp_tgt;
  logic              w_redir;
  logic [ADDR_W-1:0] w_redir_tgt;
  logic [ADDR_W-1:0] w_next_live;
  logic [ADDR_W-1:0] w_release_tgt;
  logic              w_unused_bits;

  // Next-PC candidates; all arithmetic wraps at ADDR_W bits.
  always_comb begin
    w_off_sext    = {{16{branch_offset[15]}}, branch_offset};
    w_seq         = r_pc + PC_ONE;
    w_br_tgt      = r_pc + PC_ONE + w_off_sext[ADDR_W-1:0];
    w_jmp_tgt     = jump_target[ADDR_W-1:0];
    w_redir       = jump | branch_taken;
    w_redir_tgt   = jump ? w_jmp_tgt : w_br_tgt;
    w_next_live   = w_redir ? w_redir_tgt : w_seq;
    // A buffered redirect takes precedence over this cycle's inputs on stall release.
    w_release_tgt = r_pend_valid ? r_pend_tgt : w_next_live;
    w_unused_bits = ^{w_off_sext[31:ADDR_W], jump_target[25:ADDR_W]};
  end

  // Control FSM: owns the PC, registered fetch_valid and the pending-redirect buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC[ADDR_W-1:0];
      r_fetch_valid <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_tgt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state       <= S_RUN;
            r_fetch_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (halt) begin
            r_state       <= S_HALT;
            r_fetch_valid <= 1'b0;
          end else if (stall) begin
            r_state       <= S_STALL;
            r_fetch_valid <= 1'b0;
            r_pend_valid  <= w_redir;
            r_pend_tgt    <= w_redir_tgt;
          end else if (!en) begin
            r_state       <= S_IDLE;
            r_fetch_valid <= 1'b0;
          end else begin
            r_pc <= w_next_live;
          end
        end
        S_STALL: begin
          if (halt) begin
            r_state      <= S_HALT;
            r_pend_valid <= 1'b0;
          end else if (stall) begin
            if (w_redir) begin
              r_pend_valid <= 1'b1;
              r_pend_tgt   <= w_redir_tgt;
            end
          end else begin
            r_pc         <= w_release_tgt;
            r_pend_valid <= 1'b0;
            if (en) begin
              r_state       <= S_RUN;
              r_fetch_valid <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state       <= S_IDLE;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  // Zero-extended address outputs.
  always_comb begin
    PC_Out      = '0;
    pc_plus1    = '0;
    PC_Out[ADDR_W-1:0]   = r_pc;
    pc_plus1[ADDR_W-1:0] = w_seq;
    fetch_valid = r_fetch_valid;
    state       = r_state;
  end

`ifdef FETCH_PERF_CNT_EN
  logic        w_redir_applied;
  logic [31:0] r_fetch_count;
  logic [15:0] r_redirect_count;

  // A redirect counts when it actually lands in the PC, including buffered ones.
  always_comb begin
    w_redir_applied = 1'b0;
    if (r_state == S_RUN && !halt && !stall && en && w_redir)
      w_redir_applied = 1'b1;
    if (r_state == S_STALL && !halt && !stall && (r_pend_valid || w_redir))
      w_redir_applied = 1'b1;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count    <= '0;
      r_redirect_count <= '0;
    end else begin
      if (r_fetch_valid && r_fetch_count != '1)
        r_fetch_count <= r_fetch_count + 32'd1;
      if (w_redir_applied && r_redirect_count != '1)
        r_redirect_count <= r_redirect_count + 16'd1;
    end
  end

  assign fetch_count    = r_fetch_count;
  assign redirect_count = r_redirect_count;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized run against a
// behavioural PC model computed with plain integer arithmetic.
module tb_pc_fetch_unit;

  localparam int MASK     = 31;
  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_STALL = 2;
  localparam int ST_HALT  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        halt;
  logic [31:0] PC_Out;
  logic [31:0] pc_plus1;
  logic        fetch_valid;
  logic [1:0]  state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] redirect_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_pc, m_st, m_pv, m_pt, m_fc, m_rc;

  pc_fetch_unit #(.ADDR_W(5), .RESET_PC(32'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .PC_Out        (PC_Out),
    .pc_plus1      (pc_plus1),
    .fetch_valid   (fetch_valid),
    .state         (state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .redirect_count(redirect_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0; m_st = ST_IDLE; m_pv = 0; m_pt = 0; m_fc = 0; m_rc = 0;
  endtask

  // One clock edge of the fetch rules, evaluated from the inputs present before the edge.
  task automatic model_step();
    int  tgt;
    bit  redir;
    redir = jump || branch_taken;
    if (jump) tgt = int'(jump_target) & MASK;
    else      tgt = (m_pc + 1 + int'($signed(branch_offset))) & MASK;
    if (m_st == ST_RUN) m_fc++;
    case (m_st)
      ST_IDLE: if (en) m_st = ST_RUN;
      ST_RUN: begin
        if (halt) m_st = ST_HALT;
        else if (stall) begin m_st = ST_STALL; m_pv = redir; m_pt = tgt; end
        else if (!en) m_st = ST_IDLE;
        else begin
          if (redir) m_rc++;
          m_pc = redir ? tgt : (m_pc + 1) & MASK;
        end
      end
      ST_STALL: begin
        if (halt) begin m_st = ST_HALT; m_pv = 0; end
        else if (stall) begin if (redir) begin m_pv = 1; m_pt = tgt; end end
        else begin
          if (m_pv != 0 || redir) m_rc++;
          if (m_pv != 0) m_pc = m_pt;
          else           m_pc = redir ? tgt : (m_pc + 1) & MASK;
          m_pv = 0;
          m_st = en ? ST_RUN : ST_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; branch_offset = '0; jump = 0; jump_target = '0; halt = 0;
  endtask

  // Advance one clock; outputs are stable on return (1 time unit after the edge).
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic goto_pc(input int pc);
    clear_inputs();
    jump = 1; jump_target = 26'(pc);
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    en = 0; rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    #1;
    checks++; if (PC_Out !== 32'd0) begin failures++; $display("FAIL reset_pc: got %0d expected 0", PC_Out); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fv: got %0b expected 0", fetch_valid); end
    checks++; if (pc_plus1 !== 32'd1) begin failures++; $display("FAIL reset_pcp1: got %0d expected 1", pc_plus1); end
  endtask

  task automatic test_sequential();
    en = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (PC_Out !== 32'(i)) begin failures++; $display("FAIL seq_pc[%0d]: got %0d expected %0d", i, PC_Out, i); end
      checks++; if (fetch_valid !== 1'b1 || state !== 2'b01) begin
        failures++; $display("FAIL seq_run[%0d]: got fv=%0b st=%0d expected fv=1 st=1", i, fetch_valid, state);
      end
    end
  endtask

  task automatic test_branch();
    goto_pc(10);
    branch_taken = 1; branch_offset = 16'd3;
    step();
    checks++; if (PC_Out !== 32'd14) begin failures++; $display("FAIL branch_fwd: got %0d expected 14", PC_Out); end
    goto_pc(5);
    branch_taken = 1; branch_offset = 16'hFFFE;
    step();
    checks++; if (PC_Out !== 32'd4) begin failures++; $display("FAIL branch_back: got %0d expected 4", PC_Out); end
    clear_inputs();
  endtask

  task automatic test_jump_priority();
    goto_pc(16);
    jump = 1; jump_target = 26'h14; branch_taken = 1; branch_offset = 16'd5;
    step();
    checks++; if (PC_Out !== 32'd20) begin failures++; $display("FAIL jump_prio: got %0d expected 20", PC_Out); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    goto_pc(31);
    checks++; if (pc_plus1 !== 32'd0) begin failures++; $display("FAIL wrap_pcp1: got %0d expected 0", pc_plus1); end
    step();
    checks++; if (PC_Out !== 32'd0) begin failures++; $display("FAIL wrap_pc: got %0d expected 0", PC_Out); end
    checks++; if (pc_plus1 !== 32'd1) begin failures++; $display("FAIL wrap_pcp1_after: got %0d expected 1", pc_plus1); end
  endtask

  task automatic test_stall();
    goto_pc(7);
    stall = 1; branch_taken = 1; branch_offset = 16'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin branch_taken = 0; branch_offset = '0; end
      checks++; if (PC_Out !== 32'd7 || fetch_valid !== 1'b0 || state !== 2'b10) begin
        failures++; $display("FAIL stall_hold[%0d]: got pc=%0d fv=%0b st=%0d expected pc=7 fv=0 st=2", i, PC_Out, fetch_valid, state);
      end
    end
    stall = 0;
    step();
    checks++; if (PC_Out !== 32'd10 || fetch_valid !== 1'b1 || state !== 2'b01) begin
      failures++; $display("FAIL stall_release: got pc=%0d fv=%0b st=%0d expected pc=10 fv=1 st=1", PC_Out, fetch_valid, state);
    end
  endtask

  task automatic test_halt_reset();
    goto_pc(9);
    halt = 1;
    step();
    checks++; if (state !== 2'b11 || PC_Out !== 32'd9 || fetch_valid !== 1'b0) begin
      failures++; $display("FAIL halt_enter: got pc=%0d fv=%0b st=%0d expected pc=9 fv=0 st=3", PC_Out, fetch_valid, state);
    end
    for (int i = 0; i < 5; i++) begin
      halt = 0; en = 1'($urandom); jump = 1; jump_target = 26'd3; stall = 1'($urandom);
      step();
      checks++; if (state !== 2'b11 || PC_Out !== 32'd9) begin
        failures++; $display("FAIL halt_frozen[%0d]: got pc=%0d st=%0d expected pc=9 st=3", i, PC_Out, state);
      end
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++; if (PC_Out !== 32'd0 || state !== 2'b00 || fetch_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset: got pc=%0d fv=%0b st=%0d expected pc=0 fv=0 st=0", PC_Out, fetch_valid, state);
    end
    clear_inputs(); en = 1;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_random();
    int halted = 0;
    for (int i = 0; i < 600; i++) begin
      en            = ($urandom_range(0, 9) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      halt          = ($urandom_range(0, 149) == 0);
      jump          = ($urandom_range(0, 5) == 0);
      jump_target   = 26'($urandom);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_offset = 16'($urandom);
      step();
      checks++; if (PC_Out !== 32'(m_pc) || pc_plus1 !== 32'((m_pc + 1) & MASK)) begin
        failures++; $display("FAIL rnd_pc[%0d]: got pc=%0d p1=%0d expected pc=%0d p1=%0d", i, PC_Out, pc_plus1, m_pc, (m_pc + 1) & MASK);
      end
      checks++; if (state !== m_st[1:0] || fetch_valid !== (m_st == ST_RUN)) begin
        failures++; $display("FAIL rnd_state[%0d]: got st=%0d fv=%0b expected st=%0d fv=%0b", i, state, fetch_valid, m_st, m_st == ST_RUN);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (fetch_count !== 32'(m_fc) || redirect_count !== 16'(m_rc)) begin
        failures++; $display("FAIL rnd_cnt[%0d]: got fc=%0d rc=%0d expected fc=%0d rc=%0d", i, fetch_count, redirect_count, m_fc, m_rc);
      end
`endif
      if (m_st == ST_HALT) halted++;
      if (halted >= 3) begin
        halted = 0;
        #2 rst_n = 0;
        #1 model_reset();
        @(negedge clk); rst_n = 1;
      end
    end
  endtask

  initial begin
    rst_n = 0; en = 0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_stall();
    test_halt_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
